// File: rtl/lif_scheduler.sv
// lif_scheduler
//   Round-robin arbiter that time-shares one LIF node between four requesters.
//   A granted requester's 4-bit weight is driven onto the node input lane for
//   HOLD_CYCLES cycles. The node output is then sampled and returned, tagged
//   with the requester ID, followed by a GAP_CYCLES cool-down with the lane at 0.
//
// Ports
//   clk        system clock, rising-edge
//   rst        asynchronous active-high reset
//   req_valid  per-requester burst pending
//   req_data   requester i weight in [4i+3:4i]
//   req_ready  one-hot accept pulse (IDLE only, combinational)
//   node_in    weight driven to the shared node (registered)
//   node_out   shared node output
//   resp_valid one-cycle response strobe
//   resp_id    requester ID of the response
//   resp_data  node_out sampled for that burst
//   busy       high whenever the scheduler is not IDLE
module lif_scheduler #(
  parameter int HOLD_CYCLES = 4,
  parameter int GAP_CYCLES  = 2,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  req_valid,
  input  logic [15:0] req_data,
  output logic [3:0]  req_ready,
  output logic [3:0]  node_in,
  input  logic [3:0]  node_out,
  output logic        resp_valid,
  output logic [1:0]  resp_id,
  output logic [3:0]  resp_data,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, DRIVE, SAMPLE, COOL} state_t;

  // Counter is loaded with (cycles - 1) on state entry and exits at zero.
  localparam logic [CNT_W-1:0] HOLD_LD = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] GAP_LD  = (GAP_CYCLES > 0) ? CNT_W'(GAP_CYCLES - 1) : '0;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]       ptr_q, ptr_d;
  logic [3:0]       weight_q, weight_d;
  logic [1:0]       gid_q, gid_d;
  logic [3:0]       node_in_q, node_in_d;
  logic             resp_valid_q, resp_valid_d;
  logic [1:0]       resp_id_q, resp_id_d;
  logic [3:0]       resp_data_q, resp_data_d;

  logic       found;
  logic [1:0] sel;
  logic [1:0] idx;

  // Search upward from ptr+1 with wrap; i=4 wraps back to ptr itself.
  always_comb begin
    found = 1'b0;
    sel   = ptr_q;
    idx   = '0;
    for (int i = 1; i <= 4; i++) begin
      idx = ptr_q + 2'(i);
      if (!found && req_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    ptr_d        = ptr_q;
    weight_d     = weight_q;
    gid_d        = gid_q;
    resp_valid_d = 1'b0;
    resp_id_d    = resp_id_q;
    resp_data_d  = resp_data_q;
    req_ready    = '0;
    case (state_q)
      IDLE: begin
        if (found && !rst) begin
          req_ready = 4'b0001 << sel;
          weight_d  = req_data[{sel, 2'b00} +: 4];
          gid_d     = sel;
          ptr_d     = sel;
          cnt_d     = HOLD_LD;
          state_d   = DRIVE;
        end
      end
      DRIVE: begin
        if (cnt_q == '0) begin
          state_d = SAMPLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      SAMPLE: begin
        resp_valid_d = 1'b1;
        resp_id_d    = gid_q;
        resp_data_d  = node_out;
        if (GAP_CYCLES == 0) begin
          state_d = IDLE;
        end else begin
          state_d = COOL;
          cnt_d   = GAP_LD;
        end
      end
      COOL: begin
        if (cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    // Registered lane: valid from the cycle after the grant.
    node_in_d = (state_d == DRIVE) ? weight_d : '0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= IDLE;
      cnt_q        <= '0;
      ptr_q        <= 2'd3;
      weight_q     <= '0;
      gid_q        <= '0;
      node_in_q    <= '0;
      resp_valid_q <= 1'b0;
      resp_id_q    <= '0;
      resp_data_q  <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      ptr_q        <= ptr_d;
      weight_q     <= weight_d;
      gid_q        <= gid_d;
      node_in_q    <= node_in_d;
      resp_valid_q <= resp_valid_d;
      resp_id_q    <= resp_id_d;
      resp_data_q  <= resp_data_d;
    end
  end

  assign node_in    = node_in_q;
  assign resp_valid = resp_valid_q;
  assign resp_id    = resp_id_q;
  assign resp_data  = resp_data_q;
  assign busy       = (state_q != IDLE);

endmodule

// File: tb/tb_lif_scheduler.sv
module tb_lif_scheduler;

  typedef struct {
    logic [1:0] id;
    logic [3:0] data;
    int         cyc;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  int          cyc = 0;
  int          checks = 0;
  int          errors = 0;

  // instance 0: defaults (HOLD=4, GAP=2)
  logic [3:0]  req_valid0 = '0;
  logic [15:0] req_data0 = {4'h4, 4'h9, 4'h2, 4'h1};
  logic [3:0]  req_ready0, node_in0, node_out0, resp_data0;
  logic        resp_valid0, busy0;
  logic [1:0]  resp_id0;
  logic [3:0]  acc0 = '0;

  // instance 1: HOLD=1, GAP=0
  logic [3:0]  req_valid1 = '0;
  logic [15:0] req_data1 = {4'h7, 4'h6, 4'h5, 4'h3};
  logic [3:0]  req_ready1, node_in1, node_out1, resp_data1;
  logic        resp_valid1, busy1;
  logic [1:0]  resp_id1;
  logic [3:0]  acc1 = '0;

  exp_t gq0[$], rq0[$], gq1[$], rq1[$];

  lif_scheduler u0 (
    .clk(clk), .rst(rst), .req_valid(req_valid0), .req_data(req_data0),
    .req_ready(req_ready0), .node_in(node_in0), .node_out(node_out0),
    .resp_valid(resp_valid0), .resp_id(resp_id0), .resp_data(resp_data0), .busy(busy0));

  lif_scheduler #(.HOLD_CYCLES(1), .GAP_CYCLES(0), .CNT_W(4)) u1 (
    .clk(clk), .rst(rst), .req_valid(req_valid1), .req_data(req_data1),
    .req_ready(req_ready1), .node_in(node_in1), .node_out(node_out1),
    .resp_valid(resp_valid1), .resp_id(resp_id1), .resp_data(resp_data1), .busy(busy1));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Node model: integrates nonzero input, clears when the lane is idle.
  // Output = accumulated sum + 1 (mod 16).
  always @(posedge clk) begin
    acc0 <= (node_in0 != 4'h0) ? acc0 + node_in0 : 4'h0;
    acc1 <= (node_in1 != 4'h0) ? acc1 + node_in1 : 4'h0;
  end
  assign node_out0 = acc0 + 4'h1;
  assign node_out1 = acc1 + 4'h1;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0h expected %0h", name, cyc, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int inst, input logic [1:0] id, input logic [3:0] data,
                      input int gcyc, input int rcyc, input bit with_resp);
    exp_t g, r;
    g.id = id; g.data = '0;   g.cyc = gcyc;
    r.id = id; r.data = data; r.cyc = rcyc;
    if (inst == 0) begin
      gq0.push_back(g);
      if (with_resp) rq0.push_back(r);
    end else begin
      gq1.push_back(g);
      if (with_resp) rq1.push_back(r);
    end
  endtask

  // Monitor: pops expected grants / responses whenever the DUT presents one.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (req_ready0 != 4'h0) begin
        check("u0_ready_legal", int'(req_ready0 & ~req_valid0), 0);
        if (gq0.size() == 0) check("u0_unexpected_grant", int'(req_ready0), 0);
        else begin
          e = gq0.pop_front();
          check("u0_grant_onehot", int'(req_ready0), int'(4'b0001 << e.id));
          check("u0_grant_cycle", cyc, e.cyc);
        end
      end
      if (resp_valid0) begin
        if (rq0.size() == 0) check("u0_unexpected_resp", int'(resp_id0), -1);
        else begin
          e = rq0.pop_front();
          check("u0_resp_id", int'(resp_id0), int'(e.id));
          check("u0_resp_data", int'(resp_data0), int'(e.data));
          check("u0_resp_cycle", cyc, e.cyc);
        end
      end
      if (req_ready1 != 4'h0) begin
        check("u1_ready_legal", int'(req_ready1 & ~req_valid1), 0);
        if (gq1.size() == 0) check("u1_unexpected_grant", int'(req_ready1), 0);
        else begin
          e = gq1.pop_front();
          check("u1_grant_onehot", int'(req_ready1), int'(4'b0001 << e.id));
          check("u1_grant_cycle", cyc, e.cyc);
        end
      end
      if (resp_valid1) begin
        if (rq1.size() == 0) check("u1_unexpected_resp", int'(resp_id1), -1);
        else begin
          e = rq1.pop_front();
          check("u1_resp_id", int'(resp_id1), int'(e.id));
          check("u1_resp_data", int'(resp_data1), int'(e.data));
          check("u1_resp_cycle", cyc, e.cyc);
        end
      end
    end
  end

  initial begin
    int t;
    int cnt;
    // 1. reset, idle
    tick(2);
    rst = 1'b0;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      check("idle_node_in", int'(node_in0), 0);
      check("idle_req_ready", int'(req_ready0), 0);
      check("idle_resp_valid", int'(resp_valid0), 0);
      check("idle_resp_id", int'(resp_id0), 0);
      check("idle_resp_data", int'(resp_data0), 0);
      check("idle_busy", int'(busy0), 0);
      tick(1);
    end

    // 1+3. all four valid: order 0,1,2,3,0,1, 8 cycles apart
    t = cyc;
    req_valid0 = 4'b1111;
    push(0, 2'd0, 4'h5, t,      t + 6,  1'b1);
    push(0, 2'd1, 4'h9, t + 8,  t + 14, 1'b1);
    push(0, 2'd2, 4'h5, t + 16, t + 22, 1'b1);
    push(0, 2'd3, 4'h1, t + 24, t + 30, 1'b1);
    push(0, 2'd0, 4'h5, t + 32, t + 38, 1'b1);
    push(0, 2'd1, 4'h9, t + 40, t + 46, 1'b1);
    tick(41);
    req_valid0 = 4'b0000;
    tick(7);

    // 2. single burst on requester 2, weight 9 -> response 5
    t = cyc;
    req_valid0 = 4'b0100;
    push(0, 2'd2, 4'h5, t, t + 6, 1'b1);
    @(negedge clk);
    check("t2_node_in_T", int'(node_in0), 0);
    check("t2_busy_T", int'(busy0), 0);
    tick(1);
    req_valid0 = 4'b0000;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      check("t2_node_in", int'(node_in0), (k <= 4) ? 9 : 0);
      check("t2_busy", int'(busy0), (k <= 7) ? 1 : 0);
      tick(1);
    end

    // 4. requester 1 drops during COOL; 3 then wrap to 0
    t = cyc;
    req_valid0 = 4'b0001;
    push(0, 2'd0, 4'h5, t, t + 6, 1'b1);
    tick(1);
    req_valid0 = 4'b1010;
    tick(5);
    req_valid0 = 4'b1000;
    push(0, 2'd3, 4'h1, t + 8, t + 14, 1'b1);
    tick(3);
    req_valid0 = 4'b1011;
    push(0, 2'd0, 4'h5, t + 16, t + 22, 1'b1);
    tick(8);
    req_valid0 = 4'b0000;
    tick(7);

    // 5. reset mid-burst aborts, pointer back to 3
    t = cyc;
    req_valid0 = 4'b0010;
    push(0, 2'd1, 4'h0, t, 0, 1'b0);
    tick(1);
    req_valid0 = 4'b0000;
    tick(1);
    rst = 1'b1;
    #1;
    check("t5_rst_node_in", int'(node_in0), 0);
    check("t5_rst_busy", int'(busy0), 0);
    check("t5_rst_resp_valid", int'(resp_valid0), 0);
    tick(1);
    rst = 1'b0;
    tick(6);
    t = cyc;
    req_valid0 = 4'b1000;
    push(0, 2'd3, 4'h1, t, t + 6, 1'b1);
    tick(1);
    req_valid0 = 4'b1001;
    push(0, 2'd0, 4'h5, t + 8, t + 14, 1'b1);
    tick(8);
    req_valid0 = 4'b0000;
    tick(7);

    // 6. HOLD=1 GAP=0 instance: back-to-back grants
    t = cyc;
    req_valid1 = 4'b0011;
    push(1, 2'd0, 4'h4, t,     t + 3, 1'b1);
    push(1, 2'd1, 4'h6, t + 3, t + 6, 1'b1);
    tick(1);
    req_valid1 = 4'b0010;
    @(negedge clk);
    check("t6_node_in_T1", int'(node_in1), 3);
    tick(1);
    @(negedge clk);
    check("t6_node_in_T2", int'(node_in1), 0);
    check("t6_busy_T2", int'(busy1), 1);
    tick(2);
    req_valid1 = 4'b0000;
    @(negedge clk);
    check("t6_node_in_T4", int'(node_in1), 5);
    tick(4);

    // drain, bounded
    cnt = 0;
    while ((gq0.size() + rq0.size() + gq1.size() + rq1.size()) != 0 && cnt < 50) begin
      tick(1);
      cnt++;
    end
    check("drain_pending", gq0.size() + rq0.size() + gq1.size() + rq1.size(), 0);
    check("final_busy0", int'(busy0), 0);
    check("final_busy1", int'(busy1), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
